// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and op predicates for the multiply/divide unit
package alu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } muldiv_state_t;

  // Divide family occupies the upper half of the funct3 space.
  function automatic logic is_div(muldiv_op_t op);
    return op[2];
  endfunction

  // REM/REMU return the remainder rather than the quotient.
  function automatic logic is_rem(muldiv_op_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(muldiv_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_signed_b(muldiv_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle between execute stage and muldiv unit
interface muldiv_unit_if
  import alu_pkg::*;
#(
  parameter int N = 32
) ();

  logic          in_valid;
  logic          in_ready;
  muldiv_op_t    op;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          kill;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  result;

  // Pipeline side issues requests and consumes results.
  modport master (
    output in_valid, op, a, b, kill, out_ready,
    input  in_ready, out_valid, result
  );

  // Execution unit side.
  modport slave (
    input  in_valid, op, a, b, kill, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration on the {acc, q} register pair
module muldiv_step #(
  parameter int N = 32
) (
  input  logic         div_mode,
  input  logic [N-1:0] acc_i,
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] acc_o,
  output logic [N-1:0] q_o
);

  logic [N:0] sum;
  logic [N:0] shifted;
  logic [N:0] trial;

  // Multiply: conditional add then shift {acc,q} right; divide: shift left and trial-subtract.
  always_comb begin
    sum     = {1'b0, acc_i};
    shifted = {acc_i, q_i[N-1]};
    trial   = shifted - {1'b0, b_i};
    acc_o   = acc_i;
    q_o     = q_i;
    if (div_mode) begin
      // Remainder always stays below the divisor, so N bits hold it between steps.
      if (!trial[N]) begin
        acc_o = trial[N-1:0];
        q_o   = {q_i[N-2:0], 1'b1};
      end else begin
        acc_o = shifted[N-1:0];
        q_o   = {q_i[N-2:0], 1'b0};
      end
    end else begin
      if (q_i[0]) begin
        sum = {1'b0, acc_i} + {1'b0, b_i};
      end
      acc_o = sum[N:1];
      q_o   = {sum[0], q_i[N-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RISC-V M-extension multiply/divide unit
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input logic         clk,
  input logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  muldiv_state_t state_q, state_d;
  muldiv_op_t    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  b_q, b_d;
  logic          neg_q, neg_d;
  logic          rneg_q, rneg_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  result_q, result_d;

  logic [N-1:0]   step_acc, step_q;
  logic           op_is_div;
  logic           sa, sb;
  logic [N-1:0]   a_mag, b_mag;
  logic           div_zero, div_ovf;
  logic [N-1:0]   special_res;
  logic [2*N-1:0] prod, prod_fix;
  logic [N-1:0]   quot_fix, rem_fix, final_res;

  assign op_is_div = is_div(op_q);

  muldiv_step #(.N(N)) u_step (
    .div_mode (op_is_div),
    .acc_i    (acc_q),
    .q_i      (q_q),
    .b_i      (b_q),
    .acc_o    (step_acc),
    .q_o      (step_q)
  );

  // Operand magnitudes, sign flags and the divide special cases seen at accept time.
  always_comb begin
    sa       = is_signed_a(bus.op) & bus.a[N-1];
    sb       = is_signed_b(bus.op) & bus.b[N-1];
    a_mag    = sa ? -bus.a : bus.a;
    b_mag    = sb ? -bus.b : bus.b;
    div_zero = is_div(bus.op) && (bus.b == '0);
    div_ovf  = is_div(bus.op) && is_signed_b(bus.op) &&
               (bus.a == MIN_NEG) && (bus.b == '1);
    if (is_rem(bus.op)) begin
      special_res = div_zero ? bus.a : '0;
    end else begin
      special_res = div_zero ? '1 : bus.a;
    end
  end

  // Sign fix applied to the last step's outputs as the unit enters DONE.
  always_comb begin
    prod     = {step_acc, step_q};
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -step_q : step_q;
    rem_fix  = rneg_q ? -step_acc : step_acc;
    case (op_q)
      OP_MUL:                       final_res = prod_fix[N-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*N-1:N];
      OP_DIV, OP_DIVU:              final_res = quot_fix;
      default:                      final_res = rem_fix;
    endcase
  end

  // Next-state logic: accept, iterate, hold result; kill abandons RUN or DONE.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    q_d         = q_q;
    b_d         = b_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q && !bus.kill) begin
          op_d       = bus.op;
          acc_d      = '0;
          q_d        = a_mag;
          b_d        = b_mag;
          cnt_d      = '0;
          neg_d      = sa ^ sb;
          rneg_d     = sa;
          in_ready_d = 1'b0;
          if (div_zero || div_ovf) begin
            // Result is known now; out_valid follows one edge later from DONE.
            state_d  = DONE;
            result_d = special_res;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bus.kill) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end else begin
          acc_d = step_acc;
          q_d   = step_q;
          if (cnt_q == CW'(N - 1)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = final_res;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        if (bus.kill || (out_valid_q && bus.out_ready)) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_MUL;
      cnt_q       <= '0;
      acc_q       <= '0;
      q_q         <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      q_q         <= q_d;
      b_q         <= b_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Parametrised, iterative multiply/divide execution unit implementing the RISC-V M-extension operations.
- Sits beside the combinational ALU in the execute stage.
- Accepts one operation per valid/ready handshake, computes it radix-2 over N cycles, and holds the result until the pipeline consumes it.
- Supports a kill input that abandons an in-flight operation on flush.

## Interface
Parameters:
- N, 32, operand/result width (even, ≥4)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; high only in IDLE
- op  in  3  muldiv_op_t (funct3 encoding)
- a, b  in  N  operands (rs1, rs2)
- kill  in  1  abort current operation (flush)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  N  operation result

## Operation
- **Reset values.** Reset gives state=IDLE, in_ready=1, out_valid=0, result=0.
- **States.**
  - IDLE → RUN on in_valid&in_ready, or IDLE → DONE directly for special cases.
  - RUN → DONE after N steps.
  - DONE → IDLE on out_ready.
- **Accept.** Latch op and operand magnitudes. Latch sign flags:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - DIV/REM: both signed.
  - Unsigned ops: no sign flags.
- **Multiply.** Shift-add on magnitudes into a 2N-bit product. Negate the product if the signs differ.
  - MUL returns product[N-1:0].
  - MULH/MULHSU/MULHU return product[2N-1:N].
- **Divide.** Restoring, one quotient bit per step on magnitudes.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- **Special cases.** These bypass RUN and go straight to DONE:
  - Divide by zero (b==0): quotient = all ones, remainder = a.
  - Signed overflow (a = −2^(N−1), b = −1, DIV/REM): quotient = a, remainder = 0.
- **Sign fix.** Applied when entering DONE. result is registered and stable throughout DONE.
- **Kill.** kill high in RUN or DONE → IDLE next edge; out_valid drops and no result is delivered. kill with in_valid in IDLE: no accept.
- **Priority:** reset > kill > handshake.

## Timing
- Accept edge = T. in_ready goes low from T.
- Normal ops: RUN for cycles T..T+N−1; out_valid=1 from edge T+N.
- Special cases: out_valid=1 from edge T+1.
- out_valid stays high until the edge where out_ready=1. IDLE is re-entered at that edge, and in_ready=1 the following cycle. No accept occurs in the same cycle as result consumption.
- out_ready is ignored while out_valid=0.
- Step counter: ⌈log2 N⌉ bits, counts 0..N−1, no wrap past N−1.
- Reset mid-RUN or mid-DONE → IDLE next edge, with all outputs at their reset values.

## Structure
- Package alu_pkg holds:
  - muldiv_op_t: MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - muldiv_state_t: IDLE, RUN, DONE.
  - Helper predicates is_div(op) and is_signed_a/b(op).
- One sub-module, muldiv_step:
  - Combinational single radix-2 step (add-or-shift for multiply, trial-subtract for divide).
  - Operates on the {acc, q} register pair and is parameterised by N.
- The top level contains the FSM, counter, operand registers and sign-fix logic.

## Test plan
- MUL a=7, b=0xFFFFFFFD (−3) → result 0xFFFFFFEB, out_valid exactly 32 cycles after accept; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14, REMU → 2.
- DIVU a=5, b=0 → 0xFFFFFFFF and REM 5/0 → 5, both 1 cycle after accept; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0, 1 cycle.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid → result and out_valid stable; in_ready=0 throughout; in_ready=1 the cycle after consumption.
- kill at RUN cycle 10 → no out_valid ever for that op, in_ready=1 next cycle; a following MUL 3×4 returns 12 correctly.
- reset asserted mid-RUN → next cycle in_ready=1, out_valid=0, result=0.
